// File: rtl/lfsr_shift_register.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_shift_register
//  Purpose  : Parametrised serial shift register / LFSR for the keystream
//             datapath. Supports plain shift, key/frame XOR injection, free
//             LFSR run and parallel load, either as direct single steps or
//             as a counted run of N steps launched by one start pulse.
//  Ports    : clk, rst (async, active-high)
//             en          - step enable (direct step in IDLE, stall in RUN)
//             mode[1:0]   - 00 SHIFT, 01 LFSR_XOR, 10 LFSR, 11 LOAD
//             si          - serial input bit
//             pi          - parallel load value
//             start,count - launch a counted run of 'count' steps
//             so          - register contents
//             msb_out     - so[WIDTH-1]
//             clk_bit_out - so[CLK_BIT]
//             fb          - XOR-reduce(so & TAPS), combinational
//             busy, done  - run in progress / one-cycle completion pulse
//  Options  : LFSR_ZERO_GUARD_EN - when defined, an LFSR step from the
//             all-zero state shifts in a 1 so the register cannot lock up.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_shift_register #(
    parameter int               WIDTH   = 19,
    parameter logic [WIDTH-1:0] TAPS    = 19'h72000,
    parameter int               CLK_BIT = 8,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pi,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] so,
    output logic             msb_out,
    output logic             clk_bit_out,
    output logic             fb,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_MODE_SHIFT = 2'b00;
    localparam logic [1:0] c_MODE_XOR   = 2'b01;
    localparam logic [1:0] c_MODE_LFSR  = 2'b10;
    localparam logic [1:0] c_MODE_LOAD  = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_so;
    logic [WIDTH-1:0] w_so_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;

    logic             w_fb;
    logic [1:0]       w_step_mode;
    logic             w_in_bit;
    logic [WIDTH-1:0] w_so_step;

    assign w_fb = ^(r_so & TAPS);

    // A counted run always steps in the mode captured at start; direct steps
    // follow the live mode input.
    assign w_step_mode = (r_state == c_ST_RUN) ? r_mode : mode;

    always_comb begin
        w_in_bit = si;
        case (w_step_mode)
            c_MODE_SHIFT: w_in_bit = si;
            c_MODE_XOR:   w_in_bit = w_fb ^ si;
            c_MODE_LFSR: begin
`ifdef LFSR_ZERO_GUARD_EN
                w_in_bit = (r_so == '0) ? 1'b1 : w_fb;
`else
                w_in_bit = w_fb;
`endif
            end
            default:      w_in_bit = si;
        endcase
    end

    assign w_so_step = (w_step_mode == c_MODE_LOAD) ? pi
                                                    : {r_so[WIDTH-2:0], w_in_bit};

    always_comb begin
        w_state_nxt = r_state;
        w_so_nxt    = r_so;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_mode_nxt = mode;
                    w_cnt_nxt  = count;
                    // LOAD completes in a single edge, so it goes straight
                    // to DONE together with zero-length runs.
                    if (mode == c_MODE_LOAD) begin
                        w_so_nxt    = pi;
                        w_state_nxt = c_ST_DONE;
                    end else if (count != '0) begin
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_state_nxt = c_ST_DONE;
                    end
                end else if (en) begin
                    w_so_nxt = w_so_step;
                end
            end
            c_ST_RUN: begin
                if (en) begin
                    w_so_nxt  = w_so_step;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_so    <= '0;
            r_cnt   <= '0;
            r_mode  <= c_MODE_SHIFT;
        end else begin
            r_state <= w_state_nxt;
            r_so    <= w_so_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // busy/done decode directly from state so an async reset clears them
    // without waiting for a clock edge.
    assign so          = r_so;
    assign msb_out     = r_so[WIDTH-1];
    assign clk_bit_out = r_so[CLK_BIT];
    assign fb          = w_fb;
    assign busy        = (r_state == c_ST_RUN);
    assign done        = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
